// File: rtl/clock_hms_set.sv
// -----------------------------------------------------------------------------
// clock_hms_set
// Real-time clock (HH:MM:SS) with set mode and six registered 7-segment digits.
//
// Time is held internally as six BCD digits in 24-hour format. A prescaler
// divides clk down to a 1 Hz advance. In set mode the advance is suppressed
// and the selected field can be stepped one unit per cycle with inc; each
// field wraps on its own and never carries into its neighbour.
//
// Ports
//   clk       in   single clock, all state on the rising edge
//   reset     in   asynchronous active-high reset
//   run       in   1 = timekeeping advances, 0 = time frozen
//   set_en    in   1 = set mode (1 Hz advance suppressed)
//   set_sel   in   [1:0] 00 sec, 01 min, 10 hr, 11 none
//   inc       in   increments the selected field while set_en = 1
//   mode_12h  in   1 = 12-hour display, 0 = 24-hour display
//   led_a..f  out  [6:0] digit segments a..g on bit6..bit0
//                  (a sec units, b sec tens, c min units, d min tens,
//                   e hr units, f hr tens)
//   pm        out  1 when internal hour >= 12
//   tick_1hz  out  one-cycle pulse per 1 Hz advance
// -----------------------------------------------------------------------------
module clock_hms_set #(
  parameter int CLK_HZ         = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       inc,
  input  logic       mode_12h,
  output logic [6:0] led_a,
  output logic [6:0] led_b,
  output logic [6:0] led_c,
  output logic [6:0] led_d,
  output logic [6:0] led_e,
  output logic [6:0] led_f,
  output logic       pm,
  output logic       tick_1hz
);

  localparam int            PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [6:0]    SEG_BLANK = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  // BCD pair {tens, units} incremented modulo 60.
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD hour pair incremented modulo 24.
  function automatic logic [7:0] inc_hr24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Segment code for one digit; the table is active-low, then flipped to
  // match the board polarity (blank included).
  function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
    logic [6:0] c;
    if (blank) begin
      c = 7'b1111111;
    end else begin
      case (d)
        4'd0:    c = 7'b0000001;
        4'd1:    c = 7'b1001111;
        4'd2:    c = 7'b0010010;
        4'd3:    c = 7'b0000110;
        4'd4:    c = 7'b1001100;
        4'd5:    c = 7'b0100100;
        4'd6:    c = 7'b0100000;
        4'd7:    c = 7'b0001111;
        4'd8:    c = 7'b0000000;
        4'd9:    c = 7'b0000100;
        default: c = 7'b1111111;
      endcase
    end
    return SEG_ACTIVE_LOW ? c : ~c;
  endfunction

  logic [PW-1:0] presc;
  logic [7:0]    sec, min, hr;
  logic [7:0]    sec_n, min_n, hr_n;
  logic          adv;

  assign adv = run && !set_en && (presc == PRESC_MAX);

  // ---- stage 0: prescaler and time-of-day registers ----
  // Holding the prescaler at zero for the whole of set mode covers the
  // clear-on-entry behaviour and makes the first advance after leaving set
  // mode land exactly CLK_HZ cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (set_en) begin
      presc <= '0;
    end else if (run) begin
      presc <= adv ? '0 : presc + PW'(1);
    end
  end

  // adv and set-mode edits are mutually exclusive because adv requires set_en = 0.
  always_comb begin
    sec_n = sec;
    min_n = min;
    hr_n  = hr;
    if (adv) begin
      sec_n = inc_mod60(sec);
      if (sec == 8'h59) begin
        min_n = inc_mod60(min);
        if (min == 8'h59) hr_n = inc_hr24(hr);
      end
    end else if (set_en && inc) begin
      case (set_sel)
        2'b00:   sec_n = inc_mod60(sec);
        2'b01:   min_n = inc_mod60(min);
        2'b10:   hr_n  = inc_hr24(hr);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec <= 8'h00;
      min <= 8'h00;
      hr  <= 8'h00;
    end else begin
      sec <= sec_n;
      min <= min_n;
      hr  <= hr_n;
    end
  end

  // Display hour: 24-hour value, or 12-hour mapping 0->12, 13..23->1..11.
  logic [4:0] hr_bin, disp_hr;
  logic [3:0] disp_tens, disp_units;
  logic       blank_f;

  always_comb begin
    hr_bin  = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
    disp_hr = hr_bin;
    if (mode_12h) begin
      if (hr_bin == 5'd0)       disp_hr = 5'd12;
      else if (hr_bin > 5'd12)  disp_hr = hr_bin - 5'd12;
    end
    if (disp_hr >= 5'd20)      disp_tens = 4'd2;
    else if (disp_hr >= 5'd10) disp_tens = 4'd1;
    else                       disp_tens = 4'd0;
    disp_units = 4'(disp_hr - 5'(disp_tens) * 5'd10);
    blank_f    = mode_12h && (disp_tens == 4'd0);
  end

  // ---- stage 1: registered display, pm and tick ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_a    <= SEG_BLANK;
      led_b    <= SEG_BLANK;
      led_c    <= SEG_BLANK;
      led_d    <= SEG_BLANK;
      led_e    <= SEG_BLANK;
      led_f    <= SEG_BLANK;
      pm       <= 1'b0;
      tick_1hz <= 1'b0;
    end else begin
      led_a    <= seg7(sec[3:0], 1'b0);
      led_b    <= seg7(sec[7:4], 1'b0);
      led_c    <= seg7(min[3:0], 1'b0);
      led_d    <= seg7(min[7:4], 1'b0);
      led_e    <= seg7(disp_units, 1'b0);
      led_f    <= seg7(disp_tens, blank_f);
      pm       <= (hr_bin >= 5'd12);
      tick_1hz <= adv;
    end
  end

endmodule

// File: doc/clock_hms_set.md
CLOCK_HMS_SET -- requirements
Module: clock_hms_set

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock cycles per second; legal range 2 to 2^30-1.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1; 1 = segment lit by 0, 0 = segment lit by 1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  1 = timekeeping advances; 0 = time frozen.
REQ-006 set_en  input  1  1 = set mode; 1 Hz advance suppressed.
REQ-007 set_sel  input  2  field to edit in set mode: 00 seconds, 01 minutes, 10 hours, 11 none.
REQ-008 inc  input  1  single-cycle pulse; increments the selected field in set mode.
REQ-009 mode_12h  input  1  1 = 12-hour display, 0 = 24-hour display.
REQ-010 led_a..led_f  output  7 each  seg digits: a = sec units, b = sec tens, c = min units, d = min tens, e = hr units, f = hr tens; bit6..bit0 = segments a..g.
REQ-011 pm  output  1  1 when internal hour >= 12; valid in both modes.
REQ-012 tick_1hz  output  1  one-cycle pulse on each 1 Hz advance.

Function
REQ-013 Prescaler: log2-sized counter, 0..CLK_HZ-1; increments each cycle while run=1 and set_en=0; holds otherwise.
REQ-014 Second advance: prescaler == CLK_HZ-1 with run=1 and set_en=0; prescaler -> 0, time +1 s.
REQ-015 Time held as six BCD digits, 24-hour internal format, range 00:00:00..23:59:59.
REQ-016 Carries: sec 59->00 carries to min; min 59->00 carries to hr; 23:59:59 -> 00:00:00 in one advance.
REQ-017 Digit values SHALL never leave legal BCD ranges: sec/min tens 0-5, hr tens 0-2, hr units 0-3 when hr tens = 2.
REQ-018 set_en rising edge clears prescaler to 0; first advance after set_en falls occurs exactly CLK_HZ cycles later.
REQ-019 Set mode, inc=1: selected field +1; wraps within the field (59->00, 23->00); no carry into other fields; set_sel=11 ignores inc.
REQ-020 inc with set_en=0 is ignored; inc held high increments once per cycle.
REQ-021 Display: 24-hour mode shows internal hour; 12-hour mode maps 0->12, 13..23->1..11, 1..12 unchanged.
REQ-022 12-hour mode blanks led_f (all segments off) when displayed hour tens = 0.
REQ-023 Active-low digit codes 0-9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100; SEG_ACTIVE_LOW=0 inverts every bit, blank included.
REQ-024 led_*, pm, tick_1hz are registered: they reflect a time update or mode_12h change one cycle later.
REQ-025 run=0 freezes prescaler and time; set-mode edits still apply.

Reset
REQ-026 reset=1 immediately, without clk: prescaler 0, time 00:00:00, tick_1hz 0, pm 0, all led_* blank (all segments off).
REQ-027 First clk edge after reset release drives led_* with the time digits ("00:00:00" in 24-hour mode, "12:00:00" in 12-hour mode).
REQ-028 Reset asserted mid-operation (counting or set mode) behaves identically to REQ-026; pending inc discarded.

Verification (CLK_HZ=10, SEG_ACTIVE_LOW=1)
REQ-029 Reset release, run=1, mode_12h=0 -> tick_1hz every 10 cycles; after 3 ticks led_a=0000110, led_b=0000001.
REQ-030 Preset 23:59:59 via set mode, exit, run 10 cycles -> 00:00:00, pm 1->0, single tick_1hz.
REQ-031 set_en=1, set_sel=01, 61 inc pulses from min 00 -> min 01, hours and seconds unchanged, no tick_1hz.
REQ-032 Time 13:05:00, mode_12h 0->1 -> next cycle led_f blank, led_e=1001111, pm=1; time 00:xx -> shows 12, pm=0.
REQ-033 run=0 for 25 cycles mid-second -> no tick, time and prescaler unchanged; resume counts the remaining prescaler cycles.
REQ-034 reset pulse between clk edges while set_en=1 -> outputs blank before next edge; time 00:00:00 after release.
